tcdm_error_slave: RTL and testbench
===================================

TCDM_ERROR_SLAVE -- requirements
Module: tcdm_error_slave

Interface
REQ-001 SHALL have parameter CFI_DATA_WIDTH, default 32, response data width.
REQ-002 SHALL have parameter ERR_RDATA, default 32'hBADACCE5, read data returned on every error response (zero-extended or truncated to CFI_DATA_WIDTH).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of the error counter.
REQ-004 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port req_i  in  1  TCDM request from the crossbar error port.
REQ-007 SHALL have port add_i  in  32  request byte address.
REQ-008 SHALL have port wen_i  in  1  1 = read, 0 = write.
REQ-009 SHALL have port be_i  in  4  byte enables (ignored).
REQ-010 SHALL have port wdata_i  in  CFI_DATA_WIDTH  write data (ignored).
REQ-011 SHALL have port gnt_o  out  1  request grant.
REQ-012 SHALL have port r_valid_o  out  1  response valid.
REQ-013 SHALL have port r_rdata_o  out  CFI_DATA_WIDTH  response data.
REQ-014 SHALL have port r_opc_o  out  1  response error flag.
REQ-015 SHALL have port err_clr_i  in  1  synchronous clear of the error log.
REQ-016 SHALL have port err_valid_o  out  1  sticky flag: at least one error captured.
REQ-017 SHALL have port err_addr_o  out  32  address of the first captured error.
REQ-018 SHALL have port err_wen_o  out  1  wen of the first captured error.
REQ-019 SHALL have port err_ovf_o  out  1  sticky flag: further error while err_valid_o=1.
REQ-020 SHALL have port err_cnt_o  out  CNT_WIDTH  saturating count of accepted requests.
REQ-021 SHALL have port err_irq_o  out  1  one-cycle pulse on each new capture.

Function
REQ-022 SHALL drive gnt_o = req_i combinationally; no back-pressure, no request is ever refused.
REQ-023 SHALL treat a cycle with req_i=1 as an accepted request ("accept").
REQ-024 SHALL assert r_valid_o exactly one cycle after each accept, for reads and writes alike; back-to-back accepts give back-to-back r_valid_o.
REQ-025 SHALL drive r_opc_o=1 and r_rdata_o=ERR_RDATA when r_valid_o=1, and r_opc_o=0, r_rdata_o=0 otherwise.
REQ-026 SHALL implement the log as a two-state FSM: IDLE (err_valid_o=0) and CAPTURED (err_valid_o=1).
REQ-027 IDLE + accept SHALL register add_i into err_addr_o and wen_i into err_wen_o, go to CAPTURED, and pulse err_irq_o the following cycle.
REQ-028 CAPTURED + accept SHALL leave err_addr_o and err_wen_o unchanged, set err_ovf_o, and not pulse err_irq_o.
REQ-029 err_clr_i without accept SHALL return to IDLE and zero err_addr_o, err_wen_o, err_ovf_o and err_cnt_o next cycle.
REQ-030 err_clr_i with a simultaneous accept SHALL give priority to the new request: next cycle CAPTURED, err_addr_o=add_i, err_ovf_o=0, err_cnt_o=1, err_irq_o pulses.
REQ-031 err_cnt_o SHALL increment by 1 per accept and saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-032 err_irq_o SHALL be registered and high for exactly one cycle per IDLE->CAPTURED transition.
REQ-033 Response generation SHALL be independent of err_clr_i and of the log state.

Reset
REQ-034 On rst_i=1, asynchronously: gnt_o follows req_i; r_valid_o=0, r_opc_o=0, r_rdata_o=0, err_valid_o=0, err_addr_o=0, err_wen_o=0, err_ovf_o=0, err_cnt_o=0, err_irq_o=0, FSM in IDLE.
REQ-035 A response pending when rst_i asserts SHALL be dropped; no r_valid_o while rst_i=1 or in the first cycle after release.

Verification
REQ-036 Single read, req_i=1, add_i=32'h1A10_0000, wen_i=1 -> gnt_o=1 same cycle; next cycle r_valid_o=1, r_opc_o=1, r_rdata_o=32'hBADACCE5; err_irq_o=1 one cycle; err_addr_o=32'h1A10_0000, err_wen_o=1, err_cnt_o=1.
REQ-037 Three back-to-back writes to 0x100, 0x104, 0x108 -> r_valid_o high three consecutive cycles; err_addr_o=0x100, err_wen_o=0, err_ovf_o=1, err_cnt_o=3, exactly one err_irq_o pulse.
REQ-038 CNT_WIDTH=2, five accepts -> err_cnt_o sequence 1, 2, 3, 3, 3.
REQ-039 CAPTURED, err_clr_i=1 with accept to 0x200 -> next cycle err_valid_o=1, err_addr_o=0x200, err_ovf_o=0, err_cnt_o=1, err_irq_o pulse; err_clr_i alone -> all log outputs 0.
REQ-040 rst_i asserted in the cycle after an accept -> r_valid_o stays 0 and all log outputs read 0 immediately (asynchronous).

Source files
------------

// File: rtl/tcdm_error_slave.sv
// Error slave for the TCDM crossbar: grants and error-responds to every request,
// and logs the first offending access plus overflow/count/interrupt status.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | log empty, err_valid_o=0, next accept is captured
// CAPTURED | first error held, further accepts only set ovf/count
module tcdm_error_slave #(
  parameter int unsigned CFI_DATA_WIDTH = 32,
  parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [31:0]               add_i,
  input  logic                      wen_i,
  input  logic [3:0]                be_i,
  input  logic [CFI_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [CFI_DATA_WIDTH-1:0] r_rdata_o,
  output logic                      r_opc_o,
  input  logic                      err_clr_i,
  output logic                      err_valid_o,
  output logic [31:0]               err_addr_o,
  output logic                      err_wen_o,
  output logic                      err_ovf_o,
  output logic [CNT_WIDTH-1:0]      err_cnt_o,
  output logic                      err_irq_o
);

  localparam logic [CFI_DATA_WIDTH-1:0] ERR_RDATA_W = CFI_DATA_WIDTH'(ERR_RDATA);
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                rsp_q;
  logic [31:0]         addr_q;
  logic                wen_q;
  logic                ovf_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                irq_q;
  logic                accept;
  logic                load;
  logic                unused_inputs;

  assign unused_inputs = ^{be_i, wdata_i};

  assign gnt_o  = req_i;
  assign accept = req_i;
  // A clear coinciding with a request behaves as if the log passed through IDLE.
  assign load   = accept && ((state_q == IDLE) || err_clr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)         state_d = CAPTURED;
    else if (err_clr_i) state_d = IDLE;
  end

  always_comb begin
    err_valid_o = (state_q == CAPTURED);
    r_valid_o   = rsp_q;
    r_opc_o     = rsp_q;
    r_rdata_o   = rsp_q ? ERR_RDATA_W : '0;
    err_addr_o  = addr_q;
    err_wen_o   = wen_q;
    err_ovf_o   = ovf_q;
    err_cnt_o   = cnt_q;
    err_irq_o   = irq_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rsp_q <= 1'b0;
    else       rsp_q <= accept;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      wen_q  <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      irq_q <= load;
      if (load) begin
        addr_q <= add_i;
        wen_q  <= wen_i;
      end else if (err_clr_i) begin
        addr_q <= '0;
        wen_q  <= 1'b0;
      end
      if (err_clr_i)   ovf_q <= 1'b0;
      else if (accept && (state_q == CAPTURED)) ovf_q <= 1'b1;
      if (err_clr_i)   cnt_q <= accept ? CNT_ONE : '0;
      else if (accept && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_tcdm_error_slave.sv
// Table-driven bench for tcdm_error_slave with a response scoreboard; a second
// instance with a 2-bit counter exercises saturation.
module tb_tcdm_error_slave;

  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic        clk, rst, req, wen, clr;
  logic [31:0] add, wdata;
  logic [3:0]  be;

  logic        gnt, r_valid, r_opc, e_valid, e_wen, e_ovf, e_irq;
  logic [31:0] r_rdata, e_addr;
  logic [7:0]  e_cnt;

  logic        s_gnt, s_r_valid, s_r_opc, s_e_valid, s_e_wen, s_e_ovf, s_e_irq;
  logic [31:0] s_r_rdata, s_e_addr;
  logic [1:0]  s_e_cnt;

  tcdm_error_slave dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata),
    .r_opc_o(r_opc), .err_clr_i(clr), .err_valid_o(e_valid), .err_addr_o(e_addr),
    .err_wen_o(e_wen), .err_ovf_o(e_ovf), .err_cnt_o(e_cnt), .err_irq_o(e_irq)
  );

  tcdm_error_slave #(.CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .wdata_i(wdata), .gnt_o(s_gnt), .r_valid_o(s_r_valid), .r_rdata_o(s_r_rdata),
    .r_opc_o(s_r_opc), .err_clr_i(clr), .err_valid_o(s_e_valid), .err_addr_o(s_e_addr),
    .err_wen_o(s_e_wen), .err_ovf_o(s_e_ovf), .err_cnt_o(s_e_cnt), .err_irq_o(s_e_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic        clr;
    logic        x_valid;
    logic [31:0] x_addr;
    logic        x_wen;
    logic        x_ovf;
    logic [7:0]  x_cnt;
    logic        x_irq;
  } vec_t;

  rsp_t sb[$];
  vec_t vecs[12];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [1:0] sat_exp[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_rsp();
    rsp_t r;
    r.due   = cyc + 1;
    r.rdata = ERR;
    sb.push_back(r);
  endtask

  // Advance one clock and check the response channel against the scoreboard.
  task automatic cycle();
    logic        exp_v;
    logic [31:0] exp_d;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = 1'b0;
    exp_d = 32'h0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_v = 1'b1;
      exp_d = sb[0].rdata;
      void'(sb.pop_front());
    end
    chk("r_valid", {63'b0, r_valid}, {63'b0, exp_v});
    chk("r_opc", {63'b0, r_opc}, {63'b0, exp_v});
    chk("r_rdata", {32'b0, r_rdata}, {32'b0, exp_d});
  endtask

  task automatic chk_log(input string tag, input logic v, input logic [31:0] a,
                         input logic w, input logic o, input logic [7:0] c, input logic i);
    chk({tag, ".err_valid"}, {63'b0, e_valid}, {63'b0, v});
    chk({tag, ".err_addr"}, {32'b0, e_addr}, {32'b0, a});
    chk({tag, ".err_wen"}, {63'b0, e_wen}, {63'b0, w});
    chk({tag, ".err_ovf"}, {63'b0, e_ovf}, {63'b0, o});
    chk({tag, ".err_cnt"}, {56'b0, e_cnt}, {56'b0, c});
    chk({tag, ".err_irq"}, {63'b0, e_irq}, {63'b0, i});
  endtask

  initial begin
    //          req add            wen clr  valid addr          wen ovf cnt irq
    vecs[0]  = '{1, 32'h1A10_0000, 1, 0,   1, 32'h1A10_0000, 1, 0, 1, 1};
    vecs[1]  = '{0, 32'h0,         0, 0,   1, 32'h1A10_0000, 1, 0, 1, 0};
    vecs[2]  = '{0, 32'h0,         0, 1,   0, 32'h0,         0, 0, 0, 0};
    vecs[3]  = '{1, 32'h100,       0, 0,   1, 32'h100,       0, 0, 1, 1};
    vecs[4]  = '{1, 32'h104,       0, 0,   1, 32'h100,       0, 1, 2, 0};
    vecs[5]  = '{1, 32'h108,       0, 0,   1, 32'h100,       0, 1, 3, 0};
    vecs[6]  = '{0, 32'h0,         0, 0,   1, 32'h100,       0, 1, 3, 0};
    vecs[7]  = '{1, 32'h200,       1, 1,   1, 32'h200,       1, 0, 1, 1};
    vecs[8]  = '{0, 32'h0,         0, 0,   1, 32'h200,       1, 0, 1, 0};
    vecs[9]  = '{0, 32'h0,         0, 1,   0, 32'h0,         0, 0, 0, 0};
    vecs[10] = '{0, 32'h0,         0, 0,   0, 32'h0,         0, 0, 0, 0};
    vecs[11] = '{1, 32'h3FC,       1, 0,   1, 32'h3FC,       1, 0, 1, 1};
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst = 1'b1; req = 1'b0; add = '0; wen = 1'b0; clr = 1'b0; be = '0; wdata = '0;
    #1;
    chk("rst.gnt", {63'b0, gnt}, 64'd0);
    chk("rst.r_valid", {63'b0, r_valid}, 64'd0);
    chk("rst.r_rdata", {32'b0, r_rdata}, 64'd0);
    chk_log("rst", 0, 32'h0, 0, 0, 8'd0, 0);
    req = 1'b1;
    #1;
    chk("rst.gnt_follows_req", {63'b0, gnt}, 64'd1);
    cycle();
    cycle();
    chk_log("rst_hold", 0, 32'h0, 0, 0, 8'd0, 0);
    req = 1'b0;
    rst = 1'b0;
    cycle();

    for (int k = 0; k < 12; k++) begin
      req = vecs[k].req; add = vecs[k].add; wen = vecs[k].wen; clr = vecs[k].clr;
      wdata = $urandom; be = 4'($urandom);
      #1;
      chk($sformatf("vec%0d.gnt", k), {63'b0, gnt}, {63'b0, vecs[k].req});
      if (vecs[k].req) push_rsp();
      cycle();
      chk_log($sformatf("vec%0d", k), vecs[k].x_valid, vecs[k].x_addr, vecs[k].x_wen,
              vecs[k].x_ovf, vecs[k].x_cnt, vecs[k].x_irq);
    end

    // Counter saturation: 2-bit instance must stick at 3 while the 8-bit one keeps counting.
    req = 1'b0; clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req = 1'b1; add = 32'h400 + 32'(k * 4); wen = 1'b1;
      push_rsp();
      cycle();
      chk($sformatf("sat%0d.cnt2", k), {62'b0, s_e_cnt}, {62'b0, sat_exp[k]});
      chk($sformatf("sat%0d.cnt8", k), {56'b0, e_cnt}, 64'(k + 1));
    end
    req = 1'b0;
    cycle();

    // Reset in the cycle after an accept: response and log clear immediately.
    req = 1'b1; add = 32'h500; wen = 1'b0;
    push_rsp();
    cycle();
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst.r_valid", {63'b0, r_valid}, 64'd0);
    chk("arst.r_opc", {63'b0, r_opc}, 64'd0);
    chk("arst.r_rdata", {32'b0, r_rdata}, 64'd0);
    chk_log("arst", 0, 32'h0, 0, 0, 8'd0, 0);
    cycle();
    req = 1'b0;
    rst = 1'b0;
    cycle();
    chk_log("post_rst", 0, 32'h0, 0, 0, 8'd0, 0);
    cycle();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
